// File: rtl/bcd_display_scan.sv
// bcd_display_scan: multiplexes snapshotted BCD digits onto a common-anode 7-segment display with guard, blanking and blink
module bcd_display_scan #(
    parameter int NUM_DIGITS   = 6,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD        = 64,
    parameter int BLINK_FRAMES = 60
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_V    = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    slot_end, wrap, blank;
    logic [3:0]              d;
    logic [6:0]              glyph;

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

    // Active-low glyph for the digit in the current slot; codes above 9 show a dash
    always_comb begin
        glyph = 7'h3F;
        case (d)
            4'd0: glyph = 7'h40;
            4'd1: glyph = 7'h79;
            4'd2: glyph = 7'h24;
            4'd3: glyph = 7'h30;
            4'd4: glyph = 7'h19;
            4'd5: glyph = 7'h12;
            4'd6: glyph = 7'h02;
            4'd7: glyph = 7'h78;
            4'd8: glyph = 7'h00;
            4'd9: glyph = 7'h10;
            default: glyph = 7'h3F;
        endcase
    end

    // Scan timing, frame snapshot, blink phase and next output values
    always_comb begin
        slot_end      = pre_q == PRE_LAST;
        wrap          = slot_end && idx_q == IDX_LAST;
        pre_d         = slot_end ? '0 : pre_q + 1'b1;
        idx_d         = slot_end ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
        shadow_d      = wrap ? digits_in : shadow_q;
        blink_cnt_d   = wrap ? ((blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1) : blink_cnt_q;
        blink_phase_d = blink_phase_q ^ (wrap && blink_cnt_q == BLINK_LAST);
        d             = shadow_q[4*idx_q +: 4];
        blank         = (blink_mask[idx_q] && blink_phase_q) || (blank_lz && idx_q == IDX_LAST && d == 4'd0);
        an_d          = (pre_q >= GUARD_V) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d         = blank ? 7'h7F : glyph;
        dp_d          = blank || !dp_mask[idx_q];
        frame_tick_d  = wrap;
    end

    // State and output registers; reset blanks the display and restarts the scan
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= '1;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_tick_q  <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_tick_q  <= frame_tick_d;
        end
    end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: directed scenario checks of the multiplexed display scanner
module tb_bcd_display_scan;
    localparam int ND = 6;
    localparam int RD = 4;
    localparam int FR = ND * RD;

    logic          clk = 1'b0;
    logic          reset;
    logic [23:0]   digits_in;
    logic          blank_lz;
    logic [ND-1:0] blink_mask;
    logic [ND-1:0] dp_mask;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_tick;

    int n_cmp = 0;
    int n_bad = 0;
    int s = -1;

    bcd_display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(1), .BLINK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .blank_lz(blank_lz),
        .blink_mask(blink_mask), .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        s++;
    endtask

    task automatic run_to(input int f, input int i, input int p);
        int t;
        t = f * FR + i * RD + p;
        while (s < t) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; digits_in = '0; blank_lz = 1'b0; blink_mask = '0; dp_mask = '0;
        repeat (3) tick();
        n_cmp++; if (an !== 6'h3F) begin n_bad++; $display("FAIL reset_an got %h want 3f", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got %h want 7f", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp got %b want 1", dp); end
        n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        reset = 1'b0; s = -1; digits_in = 24'h123456;
        for (int i = 0; i < ND; i++) begin
            run_to(0, i, 0);
            n_cmp++; if (an !== 6'h3F) begin n_bad++; $display("FAIL f0_guard_an slot %0d got %h want 3f", i, an); end
            run_to(0, i, 2);
            n_cmp++; if (seg !== 7'h40) begin n_bad++; $display("FAIL f0_seg slot %0d got %h want 40", i, seg); end
            n_cmp++; if (an !== (6'h3F ^ (6'd1 << i))) begin n_bad++; $display("FAIL f0_an slot %0d got %h want %h", i, an, 6'h3F ^ (6'd1 << i)); end
        end
    endtask

    task automatic test_snapshot_decode();
        logic [6:0] exp_seg [ND];
        logic [ND-1:0] exp_an;
        int ticks;
        exp_seg = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        ticks = 0;
        for (int i = 0; i < ND; i++) begin
            for (int p = 0; p < RD; p++) begin
                run_to(1, i, p);
                exp_an = (p >= 1) ? (6'h3F ^ (6'd1 << i)) : 6'h3F;
                n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL f1_an slot %0d pre %0d got %h want %h", i, p, an, exp_an); end
                n_cmp++; if (seg !== exp_seg[i]) begin n_bad++; $display("FAIL f1_seg slot %0d pre %0d got %h want %h", i, p, seg, exp_seg[i]); end
                n_cmp++; if (frame_tick !== (i == 5 && p == 3)) begin n_bad++; $display("FAIL f1_tick slot %0d pre %0d got %b want %b", i, p, frame_tick, i == 5 && p == 3); end
                if (frame_tick === 1'b1) ticks++;
            end
        end
        n_cmp++; if (ticks != 1) begin n_bad++; $display("FAIL f1_tick_count got %0d want 1", ticks); end
    endtask

    task automatic test_no_tearing();
        logic [6:0] exp_seg [ND];
        exp_seg = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        run_to(2, 2, 0);
        digits_in = 24'h000000;
        for (int i = 2; i < ND; i++) begin
            run_to(2, i, 2);
            n_cmp++; if (seg !== exp_seg[i]) begin n_bad++; $display("FAIL tear_seg slot %0d got %h want %h", i, seg, exp_seg[i]); end
        end
        for (int i = 0; i < ND; i++) begin
            run_to(3, i, 2);
            n_cmp++; if (seg !== 7'h40) begin n_bad++; $display("FAIL zero_frame_seg slot %0d got %h want 40", i, seg); end
        end
    endtask

    task automatic test_lz_invalid();
        digits_in = 24'h0A5959; blank_lz = 1'b1;
        run_to(4, 3, 2);
        n_cmp++; if (seg !== 7'h12) begin n_bad++; $display("FAIL lz_slot3_seg got %h want 12", seg); end
        run_to(4, 4, 2);
        n_cmp++; if (seg !== 7'h3F) begin n_bad++; $display("FAIL invalid_seg got %h want 3f", seg); end
        n_cmp++; if (an !== 6'b101111) begin n_bad++; $display("FAIL invalid_an got %b want 101111", an); end
        run_to(4, 5, 2);
        n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL lz_blank_seg got %h want 7f", seg); end
        n_cmp++; if (an !== 6'b011111) begin n_bad++; $display("FAIL lz_blank_an got %b want 011111", an); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL lz_blank_dp got %b want 1", dp); end
        blank_lz = 1'b0;
        run_to(5, 4, 2);
        n_cmp++; if (seg !== 7'h3F) begin n_bad++; $display("FAIL invalid_f5_seg got %h want 3f", seg); end
        run_to(5, 5, 2);
        n_cmp++; if (seg !== 7'h40) begin n_bad++; $display("FAIL no_lz_seg got %h want 40", seg); end
        n_cmp++; if (an !== 6'b011111) begin n_bad++; $display("FAIL no_lz_an got %b want 011111", an); end
    endtask

    task automatic test_blink();
        logic [6:0] normal [ND];
        logic [6:0] exp_seg;
        normal = '{7'h10, 7'h12, 7'h10, 7'h12, 7'h3F, 7'h40};
        blink_mask = 6'b000011;
        for (int f = 6; f < 10; f++) begin
            for (int i = 0; i < ND; i++) begin
                run_to(f, i, 2);
                exp_seg = ((f == 6 || f == 7) && i < 2) ? 7'h7F : normal[i];
                n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL blink_seg frame %0d slot %0d got %h want %h", f, i, seg, exp_seg); end
            end
        end
        blink_mask = '0;
    endtask

    task automatic test_dp_reset();
        dp_mask = 6'b000100;
        for (int i = 0; i < ND; i++) begin
            for (int p = 0; p < RD; p++) begin
                run_to(10, i, p);
                n_cmp++; if (dp !== (i != 2)) begin n_bad++; $display("FAIL dp slot %0d pre %0d got %b want %b", i, p, dp, i != 2); end
            end
        end
        run_to(11, 3, 1);
        reset = 1'b1;
        tick();
        n_cmp++; if (an !== 6'h3F) begin n_bad++; $display("FAIL midreset_an got %h want 3f", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL midreset_seg got %h want 7f", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL midreset_dp got %b want 1", dp); end
        n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL midreset_tick got %b want 0", frame_tick); end
        reset = 1'b0; s = -1;
        tick();
        n_cmp++; if (an !== 6'h3F) begin n_bad++; $display("FAIL restart_guard_an got %h want 3f", an); end
        n_cmp++; if (seg !== 7'h40) begin n_bad++; $display("FAIL restart_seg got %h want 40", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL restart_dp got %b want 1", dp); end
        tick();
        n_cmp++; if (an !== 6'b111110) begin n_bad++; $display("FAIL restart_an got %b want 111110", an); end
    endtask

    initial begin
        test_reset();
        test_snapshot_decode();
        test_no_tearing();
        test_lz_invalid();
        test_blink();
        test_dp_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the BCD digit counters in the digital clock.
- Takes the packed BCD time digits (HH:MM:SS) and time-multiplexes them onto a common-anode 7-segment display, one digit per slot.
- Adds an inter-digit ghosting guard, tear-free frame snapshots, leading-zero suppression on the top digit, and per-digit blinking for set mode.

Parameters:
- NUM_DIGITS, 6: number of BCD digits and anodes.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be ≥ 2.
- GUARD, 64: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ GUARD < REFRESH_DIV.
- BLINK_FRAMES, 60: complete frames per blink half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- digits_in  in  4*NUM_DIGITS  packed BCD; digit i = digits_in[4i+3:4i]; digit 0 = seconds units (rightmost).
- blank_lz  in  1  when 1, top digit (NUM_DIGITS-1) is blanked if its value is 0.
- blink_mask  in  NUM_DIGITS  digit i blinks when bit i = 1.
- dp_mask  in  NUM_DIGITS  decimal point lit on digit i when bit i = 1.
- an  out  NUM_DIGITS  anode enables, active-low; an[i] drives digit i.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal-point cathode, active-low.
- frame_tick  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (clk edge with reset=1): an all 1s, seg=7'h7F, dp=1, frame_tick=0. Internal state: pre=0, idx=0, shadow=0, blink_cnt=0, blink_phase=0.
- Reset dominates every other event, including mid-slot and mid-frame.
- Prescaler pre counts 0..REFRESH_DIV-1 and wraps to 0.
- Slot advance: at pre==REFRESH_DIV-1, idx advances; NUM_DIGITS-1 wraps to 0.
- Frame wrap = cycle where pre==REFRESH_DIV-1 and idx==NUM_DIGITS-1. On that edge:
  - shadow <= digits_in.
  - frame_tick asserts on the following cycle for exactly 1 cycle.
  - Blink counter: blink_cnt increments; on reaching BLINK_FRAMES-1 it returns to 0 and blink_phase toggles.
- digits_in changes mid-frame never affect the displayed frame. The first frame after reset displays shadow=0.
- All outputs are registered. Outputs in cycle t+1 reflect (pre, idx, shadow, blink_phase, inputs) in cycle t.
- an[i]=0 iff idx==i and pre ≥ GUARD; otherwise all anodes are 1. With GUARD=0 there is no guard interval.
- seg decode (active-low) from shadow digit d at idx:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Values 10–15 are invalid and display "-" = 7'h3F.
- Blanking: seg=7'h7F and dp=1 when either condition holds:
  - blink_mask[idx]=1 and blink_phase=1.
  - blank_lz=1, idx==NUM_DIGITS-1 and d==0.
- Otherwise dp = ~dp_mask[idx].
- blink_mask, blank_lz and dp_mask are sampled live every cycle; they are not snapshotted.
- During guard cycles seg and dp still carry the current digit's pattern; only the anodes are off.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles. Blink half-period = BLINK_FRAMES frames.

Test Plan:
Bench parameters for all scenarios: REFRESH_DIV=4, GUARD=1, NUM_DIGITS=6, BLINK_FRAMES=2. Digits are written HH:MM:SS as digits_in 24'h123456, i.e. digit0=6.
1. Reset behaviour: hold reset 3 cycles → an=6'h3F, seg=7'h7F, dp=1, frame_tick=0. Release reset → first frame shows seg=7'h40 on every active slot.
2. Snapshot and decode:
   - Drive digits_in=24'h123456 before the first wrap → second frame, slot 0: an=6'b111110 for cycles 2–4 of the slot (1 guard cycle, then 3 active), seg=7'h02.
   - Same frame, slot 5: an=6'b011111, seg=7'h79.
   - frame_tick pulses once every 24 cycles.
3. No tearing: change digits_in to 24'h000000 at slot 2 of a frame → remaining slots of that frame still show 24'h123456 digits; the next frame shows 7'h40 everywhere.
4. Leading zero and invalid codes: digits_in=24'h0A5959 with blank_lz=1 → slot 5 has seg=7'h7F with its anode still asserted; slot 4 has seg=7'h3F. With blank_lz=0 → slot 5 has seg=7'h40.
5. Blink: blink_mask=6'b000011 → digits 0–1 show seg=7'h7F for frames 2–3, normal for frames 4–5, and so on. Other digits are unaffected throughout.
6. Decimal point and mid-operation reset:
   - dp_mask=6'b000100 → dp=0 only during slot 2.
   - Assert reset mid-slot 3 → next cycle an=6'h3F, seg=7'h7F, dp=1, frame_tick=0, and the scan restarts at slot 0.
